pol_ofm_rr_sched: RTL and testbench
===================================

// Module: pol_ofm_rr_sched
// PURPOSE
//  Return-path scheduler between the POOL_CORE memory-interface channels (MIC) and the POOL_CORE pooling cores.
//  Each channel presents one Ofm beat tagged with a destination core index.
//  One arbiter per destination: round-robin with burst lock, replacing fixed-priority selection so no channel starves.
//  Zero-latency combinational data path; only grant state is registered.
// PARAMETERS
//  POOL_CORE       6    number of channels (requesters) = number of destination cores
//  POOL_COMP_CORE  64   activations per Ofm beat
//  ACT_WIDTH       8    bits per activation; beat width DW = ACT_WIDTH*POOL_COMP_CORE
//  BURST_W         4    width of cfg_burst
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 reset, synchronous, active-high
//  clr        in   1                 soft clear (layer restart), same effect as rst
//  cfg_burst  in   BURST_W           max consecutive beats per grant; 0 treated as 1
//  in_vld     in   POOL_CORE         channel c has a beat
//  in_dst     in   CW*POOL_CORE      destination core of channel c; CW = $clog2(POOL_CORE)
//  in_dat     in   DW*POOL_CORE      beat data of channel c
//  in_rdy     out  POOL_CORE         beat of channel c accepted this cycle
//  out_vld    out  POOL_CORE         core d has a beat offered
//  out_dat    out  DW*POOL_CORE      beat to core d
//  out_src    out  CW*POOL_CORE      granted channel index for core d
//  out_rdy    in   POOL_CORE         core d accepts
//  err_dst    out  1                 sticky: some in_vld seen with in_dst >= POOL_CORE
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  req[d][c] = in_vld[c] & (in_dst[c]==d); in_dst >= POOL_CORE never requests, never gets in_rdy.
//  Per-d state: ptr[d] (CW), lock[d] (1), lsrc[d] (CW), bcnt[d] (BURST_W). Two-state FSM: FREE / LOCKED.
//  Grant g[d]: LOCKED and req[d][lsrc] -> lsrc; else first c with req at or after ptr (circular).
//  LOCKED with req[d][lsrc]==0 -> act as FREE this cycle; lock<=0, bcnt<=0, ptr unchanged.
//  out_vld[d] = |req[d]; out_dat[d] = in_dat[g]; out_src[d] = g (0 when !out_vld).
//  in_rdy[c] = out_rdy[in_dst[c]] & (g[in_dst[c]]==c) & out_vld[in_dst[c]].
//  Handshake on d (out_vld & out_rdy): if bcnt+1 >= max(cfg_burst,1): ptr<=g+1 (wrap at POOL_CORE-1 -> 0), bcnt<=0, lock<=0; else bcnt<=bcnt+1, lock<=1, lsrc<=g.
//  out_vld & !out_rdy: lock<=1, lsrc<=g, bcnt held -> offered beat/source stable until accepted.
//  Channel targets one d at a time, so no cross-arbiter conflict; in_dst changes only after its handshake.
//  cfg_burst sampled per handshake; changing mid-burst takes effect at next compare.
//  rst or clr: ptr=0, lock=0, bcnt=0, err_dst=0; while asserted out_vld=0, in_rdy=0, out_src=0.
//  err_dst set on any cycle with in_vld[c] & in_dst[c]>=POOL_CORE (non power-of-2 POOL_CORE only); cleared only by rst/clr.
//  Latency 0: a beat crosses in the cycle both sides are ready; throughput 1 beat/cycle per destination.
// STRUCTURE
//  pol_pkg: POL_CW = $clog2(POOL_CORE), DW localparam, rr_first() circular priority function.
//  Sub-module pol_rr_arb_lock (one per destination, generate loop): req vector, out_rdy, cfg_burst -> grant idx/vld + state regs.
//  Top: req decode, per-d data mux, in_rdy OR-reduce, err_dst flag.
// TESTING
//  Reset: rst=1 with all in_vld=1 -> out_vld=0, in_rdy=0; after release ch0..5 all dst=0, cfg_burst=1 -> out_src[0] seq 0,1,2,3,4,5,0.
//  Burst: cfg_burst=3, ch1 and ch4 to dst 2, out_rdy=1 -> out_src[2] = 1,1,1,4,4,4,1.
//  Backpressure: ch3->dst1, out_rdy[1]=0 for 5 cycles while ch0 also requests -> out_src[1]=3 and out_dat stable all 5 cycles; in_rdy[3] only on cycle out_rdy=1.
//  Withdraw: locked on ch2 (cfg_burst=4), ch2 in_vld drops after 1 beat -> next cycle grant ch5, lock cleared, ptr unchanged.
//  Parallel: ch0->d0..ch5->d5 all out_rdy=1 -> 6 beats/cycle, out_src[d]=d, no in_rdy stall.
//  Error/clr: POOL_CORE=6, in_dst=7 on ch0 -> in_rdy[0]=0, err_dst=1 next cycle; clr pulse -> err_dst=0, ptr=0.

Source files
------------

// File: rtl/pol_pkg.sv
// Shared sizing and the circular-priority helper for the Ofm return-path scheduler.
package pol_pkg;

  localparam int POOL_CORE      = 6;
  localparam int POOL_COMP_CORE = 64;
  localparam int ACT_WIDTH      = 8;
  localparam int BURST_W        = 4;
  localparam int POL_CW         = $clog2(POOL_CORE);
  localparam int DW             = ACT_WIDTH * POOL_COMP_CORE;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // First requester at or after ptr, wrapping at POOL_CORE; 0 when nothing requests.
  function automatic logic [POL_CW-1:0] rr_first(input logic [POOL_CORE-1:0] req,
                                                 input logic [POL_CW-1:0]    ptr);
    logic found;
    int   j;
    rr_first = '0;
    found    = 1'b0;
    for (int i = 0; i < POOL_CORE; i++) begin
      j = int'(ptr) + i;
      if (j >= POOL_CORE) j = j - POOL_CORE;
      if (!found && req[j]) begin
        rr_first = POL_CW'(j);
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pol_rr_arb_lock.sv
// Per-destination round-robin arbiter with burst lock; an offered beat stays locked to
// its source until accepted, and a withdrawn lock falls back to the round-robin pointer.
module pol_rr_arb_lock
  import pol_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [POOL_CORE-1:0] req,
  input  logic                 out_rdy,
  input  logic [BURST_W-1:0]   cfg_burst,
  output logic [POL_CW-1:0]    gnt_idx,
  output logic                 gnt_vld,
  output arb_state_e           state
);

  arb_state_e           state_n;
  logic [POL_CW-1:0]    ptr, ptr_n;
  logic [POL_CW-1:0]    lsrc, lsrc_n;
  logic [BURST_W-1:0]   bcnt, bcnt_n;
  logic                 held;
  logic [BURST_W-1:0]   eff_bcnt;
  logic [BURST_W:0]     cnt_inc;
  logic [BURST_W:0]     burst_max;
  logic                 burst_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FREE;
      ptr   <= '0;
      lsrc  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      lsrc  <= lsrc_n;
      bcnt  <= bcnt_n;
    end
  end

  always_comb begin
    held      = (state == ST_LOCKED) && req[lsrc];
    gnt_vld   = |req;
    gnt_idx   = held ? lsrc : rr_first(req, ptr);
    // A withdrawn lock behaves as FREE this cycle, so its burst count does not carry over.
    eff_bcnt  = held ? bcnt : '0;
    cnt_inc   = {1'b0, eff_bcnt} + 1'b1;
    burst_max = (cfg_burst == '0) ? (BURST_W+1)'(1) : {1'b0, cfg_burst};
    burst_end = (cnt_inc >= burst_max);

    state_n = state;
    ptr_n   = ptr;
    lsrc_n  = lsrc;
    bcnt_n  = bcnt;

    if (gnt_vld && out_rdy) begin
      if (burst_end) begin
        ptr_n   = (gnt_idx == POL_CW'(POOL_CORE-1)) ? '0 : gnt_idx + 1'b1;
        bcnt_n  = '0;
        state_n = ST_FREE;
      end else begin
        bcnt_n  = cnt_inc[BURST_W-1:0];
        lsrc_n  = gnt_idx;
        state_n = ST_LOCKED;
      end
    end else if (gnt_vld) begin
      lsrc_n  = gnt_idx;
      bcnt_n  = eff_bcnt;
      state_n = ST_LOCKED;
    end else if (state == ST_LOCKED) begin
      bcnt_n  = '0;
      state_n = ST_FREE;
    end
  end

endmodule

// File: rtl/pol_ofm_rr_sched.sv
// Return-path scheduler: MIC channels to pooling cores, one locked round-robin arbiter per
// destination core, combinational data path with registered grant state only.
module pol_ofm_rr_sched
  import pol_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [BURST_W-1:0]            cfg_burst,
  input  logic [POOL_CORE-1:0]          in_vld,
  input  logic [POL_CW*POOL_CORE-1:0]   in_dst,
  input  logic [DW*POOL_CORE-1:0]       in_dat,
  output logic [POOL_CORE-1:0]          in_rdy,
  output logic [POOL_CORE-1:0]          out_vld,
  output logic [DW*POOL_CORE-1:0]       out_dat,
  output logic [POL_CW*POOL_CORE-1:0]   out_src,
  input  logic [POOL_CORE-1:0]          out_rdy,
  output logic                          err_dst,
  output logic [POOL_CORE-1:0]          dbg_lock
);

  // Handshake: a beat moves on destination d in any cycle with out_vld[d] & out_rdy[d];
  // the granted channel sees in_rdy in that same cycle, and an unaccepted offer holds its
  // source and data until it is taken.

  logic                 rst_any;
  logic [POOL_CORE-1:0] req [POOL_CORE];
  logic [POL_CW-1:0]    gnt [POOL_CORE];
  logic [POOL_CORE-1:0] gnt_vld;
  arb_state_e           arb_state [POOL_CORE];
  logic                 bad_dst;

  assign rst_any = rst | clr;

  always_comb begin
    for (int d = 0; d < POOL_CORE; d++) begin
      req[d] = '0;
      for (int c = 0; c < POOL_CORE; c++)
        req[d][c] = in_vld[c] & ~rst_any & (in_dst[c*POL_CW +: POL_CW] == POL_CW'(d));
    end
  end

  for (genvar d = 0; d < POOL_CORE; d++) begin : g_arb
    pol_rr_arb_lock u_arb (
      .clk       (clk),
      .rst       (rst_any),
      .req       (req[d]),
      .out_rdy   (out_rdy[d]),
      .cfg_burst (cfg_burst),
      .gnt_idx   (gnt[d]),
      .gnt_vld   (gnt_vld[d]),
      .state     (arb_state[d])
    );
  end

  always_comb begin
    out_vld  = '0;
    out_dat  = '0;
    out_src  = '0;
    dbg_lock = '0;
    for (int d = 0; d < POOL_CORE; d++) begin
      out_vld[d]  = gnt_vld[d];
      dbg_lock[d] = (arb_state[d] == ST_LOCKED);
      if (gnt_vld[d]) begin
        out_src[d*POL_CW +: POL_CW] = gnt[d];
        out_dat[d*DW +: DW]         = in_dat[int'(gnt[d])*DW +: DW];
      end
    end
  end

  always_comb begin
    in_rdy  = '0;
    bad_dst = 1'b0;
    for (int c = 0; c < POOL_CORE; c++) begin
      if (in_vld[c] && int'(in_dst[c*POL_CW +: POL_CW]) >= POOL_CORE) bad_dst = 1'b1;
      for (int d = 0; d < POOL_CORE; d++)
        if ((in_dst[c*POL_CW +: POL_CW] == POL_CW'(d)) && out_vld[d] && out_rdy[d] &&
            (gnt[d] == POL_CW'(c)))
          in_rdy[c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_any)      err_dst <= 1'b0;
    else if (bad_dst) err_dst <= 1'b1;
  end

endmodule

// File: tb/tb_pol_ofm_rr_sched.sv
// Directed bench for pol_ofm_rr_sched: per-destination expected-beat queues drained by a monitor.
module tb_pol_ofm_rr_sched;
  import pol_pkg::*;

  localparam int EW = POL_CW + DW;

  logic                        clk;
  logic                        rst;
  logic                        clr;
  logic [BURST_W-1:0]          cfg_burst;
  logic [POOL_CORE-1:0]        in_vld;
  logic [POL_CW*POOL_CORE-1:0] in_dst;
  logic [DW*POOL_CORE-1:0]     in_dat;
  logic [POOL_CORE-1:0]        in_rdy;
  logic [POOL_CORE-1:0]        out_vld;
  logic [DW*POOL_CORE-1:0]     out_dat;
  logic [POL_CW*POOL_CORE-1:0] out_src;
  logic [POOL_CORE-1:0]        out_rdy;
  logic                        err_dst;
  logic [POOL_CORE-1:0]        dbg_lock;

  int errors = 0;
  int checks = 0;
  int cur_tag = 0;

  logic [EW-1:0] exp_q [POOL_CORE][$];
  logic [EW-1:0] mon_e;

  pol_ofm_rr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .cfg_burst (cfg_burst),
    .in_vld    (in_vld),
    .in_dst    (in_dst),
    .in_dat    (in_dat),
    .in_rdy    (in_rdy),
    .out_vld   (out_vld),
    .out_dat   (out_dat),
    .out_src   (out_src),
    .out_rdy   (out_rdy),
    .err_dst   (err_dst),
    .dbg_lock  (dbg_lock)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [DW-1:0] tb_dat(input int c, input int tag);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < POOL_COMP_CORE; k++)
      r[k*ACT_WIDTH +: ACT_WIDTH] = ACT_WIDTH'((c*37 + k*3 + tag*11) & 255);
    return r;
  endfunction

  // driver tasks
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_dat(input int tag);
    cur_tag = tag;
    for (int c = 0; c < POOL_CORE; c++) in_dat[c*DW +: DW] = tb_dat(c, tag);
  endtask

  task automatic set_dst(input int c, input int d);
    in_dst[c*POL_CW +: POL_CW] = POL_CW'(d);
  endtask

  task automatic push_exp(input int d, input int src);
    exp_q[d].push_back({POL_CW'(src), tb_dat(src, cur_tag)});
  endtask

  task automatic clr_pulse();
    in_vld = '0;
    clr = 1'b1;
    run(1);
    clr = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int d = 0; d < POOL_CORE; d++) begin
      if (out_vld[d] && out_rdy[d]) begin
        checks++;
        if (exp_q[d].size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat d=%0d src=%0d", d, out_src[d*POL_CW +: POL_CW]);
        end else begin
          mon_e = exp_q[d].pop_front();
          if (out_src[d*POL_CW +: POL_CW] !== mon_e[DW +: POL_CW] ||
              out_dat[d*DW +: DW] !== mon_e[DW-1:0]) begin
            errors++;
            $display("FAIL beat d=%0d: src got %0d expected %0d, dat got %h expected %h",
                     d, out_src[d*POL_CW +: POL_CW], mon_e[DW +: POL_CW],
                     out_dat[d*DW +: DW], mon_e[DW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    cfg_burst = 4'd1;
    in_vld = '1;
    in_dst = '0;
    out_rdy = '1;
    load_dat(0);
    run(2);

    // reset: requests present but nothing offered or accepted
    @(negedge clk);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_err_dst", 64'(err_dst), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // all channels to core 0, burst 1: plain rotation
    for (int s = 0; s < 7; s++) push_exp(0, s % 6);
    @(negedge clk);
    check("rr_first_in_rdy", 64'(in_rdy), 64'h01);
    @(posedge clk);
    #1;
    run(6);
    in_vld = '0;

    // burst of 3: ch1 and ch4 to core 2
    load_dat(1);
    clr_pulse();
    cfg_burst = 4'd3;
    set_dst(1, 2);
    set_dst(4, 2);
    in_vld = 6'b010010;
    push_exp(2, 1); push_exp(2, 1); push_exp(2, 1);
    push_exp(2, 4); push_exp(2, 4); push_exp(2, 4);
    push_exp(2, 1);
    run(7);
    in_vld = '0;

    // backpressure on core 1: ch3 offered alone first, then ch0 joins
    load_dat(2);
    clr_pulse();
    cfg_burst = 4'd1;
    set_dst(3, 1);
    set_dst(0, 1);
    out_rdy[1] = 1'b0;
    in_vld = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_src", 64'(out_src[1*POL_CW +: POL_CW]), 64'd3);
      check("bp_out_vld", 64'(out_vld[1]), 64'd1);
      check("bp_in_rdy", 64'(in_rdy), 64'd0);
      check_dat("bp_out_dat", out_dat[1*DW +: DW], tb_dat(3, 2));
      @(posedge clk);
      #1;
      in_vld = 6'b001001;
    end
    out_rdy[1] = 1'b1;
    push_exp(1, 3);
    push_exp(1, 0);
    @(negedge clk);
    check("bp_release_in_rdy", 64'(in_rdy), 64'h08);
    @(posedge clk);
    #1;
    run(1);
    in_vld = '0;

    // withdraw: ch2 locks core 3 with burst 4, then drops out
    load_dat(3);
    clr_pulse();
    cfg_burst = 4'd4;
    set_dst(0, 3);
    set_dst(2, 3);
    set_dst(5, 3);
    in_vld = 6'b100100;
    push_exp(3, 2);
    push_exp(3, 5);
    push_exp(3, 0);
    run(1);
    in_vld = 6'b100000;
    @(negedge clk);
    check("wd_locked", 64'(dbg_lock[3]), 64'd1);
    @(posedge clk);
    #1;
    in_vld = 6'b000101;
    run(1);
    in_vld = '0;
    run(1);
    @(negedge clk);
    check("wd_idle_unlocked", 64'(dbg_lock), 64'd0);
    @(posedge clk);
    #1;

    // parallel: each channel to its own core
    load_dat(4);
    clr_pulse();
    cfg_burst = 4'd1;
    for (int c = 0; c < POOL_CORE; c++) begin
      set_dst(c, c);
      push_exp(c, c);
      push_exp(c, c);
    end
    in_vld = '1;
    @(negedge clk);
    check("par_in_rdy", 64'(in_rdy), 64'h3F);
    check("par_out_vld", 64'(out_vld), 64'h3F);
    @(posedge clk);
    #1;
    run(1);
    in_vld = '0;

    // bad destination and clr: move ptr[4] first so the clr is observable
    load_dat(5);
    clr_pulse();
    set_dst(2, 4);
    in_vld = 6'b000100;
    push_exp(4, 2);
    run(1);
    set_dst(0, 7);
    in_vld = 6'b000001;
    @(negedge clk);
    check("err_in_rdy", 64'(in_rdy), 64'd0);
    check("err_out_vld", 64'(out_vld), 64'd0);
    check("err_not_yet", 64'(err_dst), 64'd0);
    @(posedge clk);
    #1;
    in_vld = '0;
    @(negedge clk);
    check("err_set", 64'(err_dst), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("err_sticky", 64'(err_dst), 64'd1);
    @(posedge clk);
    #1;
    set_dst(1, 4);
    set_dst(5, 4);
    in_vld = 6'b100010;
    clr = 1'b1;
    @(negedge clk);
    check("clr_out_vld", 64'(out_vld), 64'd0);
    check("clr_in_rdy", 64'(in_rdy), 64'd0);
    check("clr_out_src", 64'(out_src), 64'd0);
    push_exp(4, 1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_err_dst", 64'(err_dst), 64'd0);
    @(posedge clk);
    #1;
    in_vld = '0;
    run(2);

    for (int d = 0; d < POOL_CORE; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("FAIL drain d=%0d: %0d beats still expected, required 0", d, exp_q[d].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
